polarity_pipe: RTL

- Parametrised successor to the single-bit combinational inverter.
- A WIDTH-bit, STAGES-deep registered pipeline with valid/ready flow control.
- Applies a selectable polarity transform (pass, invert all, invert by mask, invert alternate samples) at the input stage.
- Sits between lab stimulus sources and display/consumer logic; also counts completed output transfers.

---
 rtl/polarity_pipe_if.sv | 31 +++
 rtl/polarity_pipe.sv | 85 ++++++++
 2 files changed

// File: rtl/polarity_pipe_if.sv
// polarity_pipe_if: bundles the sample stream, transform controls and output
// stream of polarity_pipe.
//   master modport: stimulus side (drives in_*, mode, mask_*, out_ready)
//   slave modport : the pipeline itself
//   in_valid/in_ready/in_data    : input sample handshake
//   mode                         : transform select applied at acceptance
//   mask_load/mask_in            : mask register write strobe and value
//   out_valid/out_ready/out_data : output sample handshake
interface polarity_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       mode;
   logic             mask_load;
   logic [WIDTH-1:0] mask_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, mode, mask_load, mask_in, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, mode, mask_load, mask_in, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/polarity_pipe.sv
// polarity_pipe: STAGES-deep registered valid/ready pipeline that applies a
// polarity transform (pass, invert, XOR mask, invert odd samples) as a sample
// enters stage 0, and counts completed output transfers.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : polarity_pipe_if slave (input/output streams, mode, mask)
//   xfer_count : output handshakes completed, modulo 2^COUNT_W
module polarity_pipe #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned STAGES  = 2,
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   polarity_pipe_if.slave     bus,
   output logic [COUNT_W-1:0] xfer_count
);

   logic [STAGES-1:0] v_q;
   logic [WIDTH-1:0]  d_q [STAGES];
   logic [STAGES-1:0] ready;
   logic [WIDTH-1:0]  mask_q;
   logic              toggle_q;
   logic [COUNT_W-1:0] xfer_q;
   logic              accept;
   logic              xfer;
   logic [WIDTH-1:0]  xform;

   // ready[i] = ~v[i] | ready[i+1], unrolled as a running OR from the output
   // end so the vector never depends on itself.
   always_comb begin
      logic r;
      r     = bus.out_ready;
      ready = '0;
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
         r        = r | ~v_q[i];
         ready[i] = r;
      end
   end

   assign accept = bus.in_valid & ready[0];
   assign xfer   = v_q[STAGES-1] & bus.out_ready;

   always_comb begin
      xform = bus.in_data;
      unique case (bus.mode)
         2'b00: xform = bus.in_data;
         2'b01: xform = ~bus.in_data;
         2'b10: xform = bus.in_data ^ mask_q;
         2'b11: xform = toggle_q ? ~bus.in_data : bus.in_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q      <= '0;
         for (int i = 0; i < int'(STAGES); i++) d_q[i] <= '0;
         mask_q   <= '0;
         toggle_q <= 1'b0;
         xfer_q   <= '0;
      end else begin
         if (ready[0]) begin
            v_q[0] <= accept;
            if (accept) d_q[0] <= xform;
         end
         // Data only moves with a valid sample so idle outputs stay quiet.
         for (int i = 1; i < int'(STAGES); i++) begin
            if (ready[i]) begin
               v_q[i] <= v_q[i-1];
               if (v_q[i-1]) d_q[i] <= d_q[i-1];
            end
         end
         // Mask written here is seen by the next cycle's acceptance.
         if (bus.mask_load) mask_q <= bus.mask_in;
         if (accept) toggle_q <= ~toggle_q;
         if (xfer) xfer_q <= xfer_q + COUNT_W'(1);
      end
   end

   assign bus.in_ready  = ready[0];
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.out_data  = d_q[STAGES-1];
   assign xfer_count    = xfer_q;

endmodule
